heartbeat_generator: RTL and testbench

Source end of the watchdog heartbeat interface. It emits periodic single-cycle heartbeat pulses toward the watchdog timer and accepts software "kick" requests through a four-phase req/ack handshake. It monitors the watchdog's warning and triggered outputs, issues a recovery beat on warning, and latches a fault on trigger. It sits in the control plane beside the watchdog, driven by the register/SCPI layer.

---
 rtl/hb_pkg.sv | 24 ++
 rtl/heartbeat_generator.sv | 113 +++++++++++
 tb/tb_heartbeat_generator.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hb_pkg.sv
// Shared types and constants for the watchdog heartbeat source.
package hb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_FAULT  = 2'd3
  } hb_state_t;

  localparam int unsigned HB_MIN_PERIOD = 2;

  // Status register map encodings of the state field.
  localparam logic [1:0] HB_ST_IDLE   = 2'd0;
  localparam logic [1:0] HB_ST_RUN    = 2'd1;
  localparam logic [1:0] HB_ST_PAUSED = 2'd2;
  localparam logic [1:0] HB_ST_FAULT  = 2'd3;

  function automatic logic [31:0] hb_clamp_period(input logic [31:0] p,
                                                  input logic [31:0] min_p);
    return (p < min_p) ? min_p : p;
  endfunction

endpackage

// File: rtl/heartbeat_generator.sv
// Periodic heartbeat source for the watchdog: kick handshake, recovery beat on
// warning, fault latch on trigger.
module heartbeat_generator
  import hb_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 125_000_000,
  parameter int unsigned MIN_PERIOD = HB_MIN_PERIOD,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic [31:0]        period_cycles,
  input  logic               pause,
  input  logic               kick_req,
  output logic               kick_ack,
  input  logic               wd_warning,
  input  logic               wd_triggered,
  output logic               heartbeat,
  output logic [COUNT_W-1:0] beat_count,
  output logic               fault,
  output logic [1:0]         state
);

  if (MIN_PERIOD < 2 || CLK_FREQ == 0) begin : g_bad_param
    $error("heartbeat_generator: MIN_PERIOD must be >= 2 and CLK_FREQ nonzero");
  end

  hb_state_t          state_q;
  logic [31:0]        cnt_q;
  logic [31:0]        plat_q;
  logic               hb_q;
  logic               ack_q;
  logic               fault_q;
  logic               warn_q;
  logic [COUNT_W-1:0] bc_q;

  logic active;
  logic kick;
  logic expiry;
  logic warn_rise;
  logic beat;

  // All beat sources collapse into one pulse; the trigger check in the FSM
  // below drops it when wd_triggered is sampled in the same cycle.
  always_comb begin
    active    = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    kick      = active && kick_req && !ack_q;
    expiry    = (state_q == ST_RUN) && (cnt_q == plat_q - 32'd1);
    warn_rise = (state_q == ST_RUN) && wd_warning && !warn_q;
    beat      = kick || expiry || warn_rise;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      plat_q  <= 32'(MIN_PERIOD);
      hb_q    <= 1'b0;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
      warn_q  <= 1'b0;
      bc_q    <= '0;
    end else begin
      warn_q <= wd_warning;
      hb_q   <= 1'b0;
      if (!enable) begin
        state_q <= ST_IDLE;
        ack_q   <= 1'b0;
        cnt_q   <= '0;
        fault_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            plat_q  <= hb_clamp_period(period_cycles, 32'(MIN_PERIOD));
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            state_q <= ST_RUN;
          end
          ST_RUN, ST_PAUSED: begin
            if (wd_triggered) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
              ack_q   <= 1'b0;
            end else begin
              if (kick)          ack_q <= 1'b1;
              else if (!kick_req) ack_q <= 1'b0;
              if (beat) begin
                hb_q  <= 1'b1;
                bc_q  <= bc_q + COUNT_W'(1);
                cnt_q <= '0;
              end else if (state_q == ST_RUN) begin
                cnt_q <= cnt_q + 32'd1;
              end
              if (state_q == ST_RUN && pause)         state_q <= ST_PAUSED;
              else if (state_q == ST_PAUSED && !pause) state_q <= ST_RUN;
            end
          end
          default: begin
            ack_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign heartbeat  = hb_q;
  assign kick_ack   = ack_q;
  assign fault      = fault_q;
  assign beat_count = bc_q;
  assign state      = state_q;

endmodule

// File: tb/tb_heartbeat_generator.sv
// Self-checking bench for heartbeat_generator: cycle model plus directed vectors.
module tb_heartbeat_generator;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] period_cycles = 32'd0;
  logic        pause = 1'b0;
  logic        kick_req = 1'b0;
  logic        wd_warning = 1'b0;
  logic        wd_triggered = 1'b0;

  logic        kick_ack, heartbeat, fault;
  logic [15:0] beat_count;
  logic [1:0]  state;
  logic        kick_ack4, heartbeat4, fault4;
  logic [3:0]  beat_count4;
  logic [1:0]  state4;

  int unsigned total = 0;
  int unsigned bad = 0;
  bit          cmp_on = 1'b0;
  bit          prev_hb = 1'b0;

  always #5 clk = ~clk;

  heartbeat_generator #(.COUNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .period_cycles(period_cycles),
    .pause(pause), .kick_req(kick_req), .kick_ack(kick_ack),
    .wd_warning(wd_warning), .wd_triggered(wd_triggered),
    .heartbeat(heartbeat), .beat_count(beat_count), .fault(fault), .state(state)
  );

  heartbeat_generator #(.COUNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .enable(enable), .period_cycles(period_cycles),
    .pause(pause), .kick_req(kick_req), .kick_ack(kick_ack4),
    .wd_warning(wd_warning), .wd_triggered(wd_triggered),
    .heartbeat(heartbeat4), .beat_count(beat_count4), .fault(fault4), .state(state4)
  );

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: mode 0 idle, 1 running, 2 paused, 3 faulted; since_beat counts
  // cycles elapsed since the last beat (or since start / last reset).
  int unsigned mode = 0;
  int unsigned since_beat = 0;
  int unsigned period = 2;
  int unsigned pulses = 0;
  bit          m_hb = 0, m_ack = 0, m_fault = 0, m_warn = 0;
  bit          due, kicked, wrise;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode = 0; since_beat = 0; period = 2; pulses = 0;
      m_hb = 0; m_ack = 0; m_fault = 0; m_warn = 0;
    end else begin
      wrise  = wd_warning && !m_warn;
      m_warn = wd_warning;
      m_hb   = 0;
      if (!enable) begin
        mode = 0; m_ack = 0; since_beat = 0; m_fault = 0;
      end else if (mode == 0) begin
        period = (period_cycles < 2) ? 2 : period_cycles;
        since_beat = 0; m_ack = 0; mode = 1;
      end else if (mode == 3) begin
        m_ack = 0;
      end else if (wd_triggered) begin
        mode = 3; m_fault = 1; m_ack = 0;
      end else begin
        kicked = kick_req && !m_ack;
        if (kicked) m_ack = 1;
        else if (!kick_req) m_ack = 0;
        due = kicked;
        if (mode == 1) begin
          if (since_beat + 1 >= period || wrise) due = 1;
          since_beat = due ? 0 : since_beat + 1;
          if (pause) mode = 2;
        end else begin
          if (due) since_beat = 0;
          if (!pause) mode = 1;
        end
        if (due) begin
          m_hb = 1;
          pulses++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("hb", heartbeat, m_hb);
      chk("ack", kick_ack, m_ack);
      chk("fault", fault, m_fault);
      chk("state", state, mode);
      chk("bc", beat_count, pulses % 65536);
      chk("hb4", heartbeat4, m_hb);
      chk("bc4", beat_count4, pulses % 16);
      chk("hb_consec", heartbeat & prev_hb, 0);
      prev_hb = heartbeat;
    end
  end

  initial begin
    int n;
    tick(1);
    chk("rst_state", state, 0);
    chk("rst_bc", beat_count, 0);
    chk("rst_hb", heartbeat, 0);
    chk("rst_ack", kick_ack, 0);
    chk("rst_fault", fault, 0);
    cmp_on = 1'b1;
    rstn = 1'b1;
    tick(1);

    enable = 1'b1;
    period_cycles = 32'd10;
    for (int i = 0; i < 35; i++) begin
      tick(1);
      chk("p10_hb", heartbeat, (i == 10 || i == 20 || i == 30) ? 1 : 0);
    end
    chk("p10_bc", beat_count, 3);
    chk("p10_state", state, 1);
    period_cycles = 32'd3;

    kick_req = 1'b1;
    tick(1);
    chk("kick_hb", heartbeat, 1);
    chk("kick_ack", kick_ack, 1);
    chk("kick_bc", beat_count, 4);
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      chk("kick_hold_hb", heartbeat, (k == 10) ? 1 : 0);
    end
    chk("kick_hold_ack", kick_ack, 1);
    kick_req = 1'b0;
    tick(1);
    chk("kick_release_ack", kick_ack, 0);

    tick(7);
    kick_req = 1'b1;
    tick(1);
    chk("kick_exp_hb", heartbeat, 1);
    chk("kick_exp_bc", beat_count, 6);
    kick_req = 1'b0;
    tick(1);
    chk("kick_exp_after", heartbeat, 0);

    tick(2);
    pause = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick(1);
      chk("pause_hb", heartbeat, 0);
    end
    chk("pause_state", state, 2);
    kick_req = 1'b1;
    tick(1);
    chk("pkick_hb", heartbeat, 1);
    chk("pkick_ack", kick_ack, 1);
    chk("pkick_bc", beat_count, 7);
    kick_req = 1'b0;
    pause = 1'b0;
    for (int m = 1; m <= 11; m++) begin
      tick(1);
      chk("resume_hb", heartbeat, (m == 11) ? 1 : 0);
    end

    tick(3);
    wd_warning = 1'b1;
    tick(1);
    chk("warn_hb", heartbeat, 1);
    chk("warn_bc", beat_count, 9);
    for (int m = 1; m <= 10; m++) begin
      tick(1);
      chk("warn_after_hb", heartbeat, (m == 10) ? 1 : 0);
    end
    wd_triggered = 1'b1;
    kick_req = 1'b1;
    tick(1);
    chk("trig_state", state, 3);
    chk("trig_fault", fault, 1);
    chk("trig_hb", heartbeat, 0);
    chk("trig_ack", kick_ack, 0);
    tick(5);
    chk("fault_hold_hb", heartbeat, 0);
    chk("fault_hold_bc", beat_count, 10);
    wd_triggered = 1'b0;
    enable = 1'b0;
    tick(1);
    chk("dis_state", state, 0);
    chk("dis_fault", fault, 0);
    chk("idle_ack", kick_ack, 0);
    kick_req = 1'b0;
    wd_warning = 1'b0;

    period_cycles = 32'd0;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("clamp_hb", heartbeat, (i >= 2 && i % 2 == 0) ? 1 : 0);
    end
    chk("clamp_bc", beat_count, 14);

    n = 0;
    while (beat_count4 != 4'd15 && n < 100) begin
      tick(1);
      n++;
    end
    chk("wrap_reach", beat_count4, 15);
    n = 0;
    tick(1);
    while (!heartbeat4 && n < 100) begin
      tick(1);
      n++;
    end
    chk("wrap_val", beat_count4, 0);
    chk("wrap_bc16", beat_count, 16);

    #2 rstn = 1'b0;
    #1;
    chk("arst_hb", heartbeat, 0);
    chk("arst_bc", beat_count, 0);
    chk("arst_state", state, 0);
    chk("arst_ack", kick_ack, 0);
    chk("arst_fault", fault, 0);
    chk("arst_bc4", beat_count4, 0);
    tick(2);
    rstn = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
